// File: rtl/proc_pkg.sv
// Shared types for the processor front end: fetch FSM states and prefetch queue entries.
// No logic; pure declarations.
// Imported by instr_fetch and fetch_queue.
package proc_pkg;

  localparam int INSTR_W      = 16;
  localparam int FETCH_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Purpose: 2-entry prefetch FIFO of {instr, pc}; head is a register, not a mux.
// Latency: push visible at head_dat/head_vld one cycle later.
// Backpressure: none internally; caller never pushes into a full queue unless popping.
// Ports: push_vld/push_dat (tail), pop (head consume), flush (clear all),
//        count (occupancy 0..2), head_vld/head_dat (to decoder).
module fetch_queue
  import proc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_vld,
  output fetch_entry_t head_dat
);

  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic [1:0]   cnt;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (cnt != 2'd0) && !flush;
  // A full queue accepts a push only when the head leaves in the same cycle.
  assign do_push = push_vld && !flush && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      cnt   <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) slot0 <= push_dat;
          else             slot1 <= push_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            slot0 <= push_dat;
          end else begin
            slot0 <= slot1;
            slot1 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign count    = cnt;
  assign head_vld = (cnt != 2'd0);
  assign head_dat = slot0;

endmodule

// File: rtl/instr_fetch.sv
// Purpose: fetch stage; owns PC, issues single-outstanding imem reads, feeds decoder via 2-entry queue.
// Latency: req->gnt->rvalid->ir_valid; instruction visible one cycle after its rvalid.
// Backpressure: ir_ready low fills the queue; no new request is issued without a free slot.
// Ports: imem_req/addr/gnt/rvalid/rdata (memory), ir/ir_pc/ir_valid/ir_ready (decoder),
//        redirect/redirect_pc (branch flush), halt/halted (external stop).
module instr_fetch
  import proc_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               halted
);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              discard;
  logic [1:0]        q_count;
  logic              head_vld;
  fetch_entry_t      head_dat;
  fetch_entry_t      push_dat;
  logic              gnt_fire;
  logic              resp_fire;
  logic              push_vld;
  logic              pop;

  assign gnt_fire  = (state == REQ) && imem_gnt;
  assign resp_fire = (state == WAIT) && imem_rvalid;
  // A response that lands in the redirect cycle belongs to the old path.
  assign push_vld  = resp_fire && !discard && !redirect;
  assign pop       = head_vld && ir_ready;
  assign push_dat  = '{instr: imem_rdata, pc: FETCH_ADDR_W'(inflight_pc)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      discard     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect)      pc <= redirect_pc;
      else if (gnt_fire) pc <= pc + ADDR_W'(1);
      if (gnt_fire) inflight_pc <= pc;
      // Redirect with a request in flight (already waiting, or granted this
      // cycle) marks its eventual response as stale.
      if (redirect && ((state == WAIT && !imem_rvalid) || gnt_fire)) discard <= 1'b1;
      else if (resp_fire)                                            discard <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    halted    = 1'b0;
    case (state)
      IDLE: begin
        if (halt)                 state_nxt = HALTED;
        else if (q_count < 2'd2)  state_nxt = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) state_nxt = IDLE;
      end
      HALTED: begin
        halted = 1'b1;
        if (!halt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Redirect restarts from IDLE unless a request is (or just became) outstanding,
    // in which case WAIT absorbs the stale response; HALTED keeps its own exit rule.
    if (redirect) begin
      if (state == IDLE)                 state_nxt = IDLE;
      else if (state == REQ && !imem_gnt) state_nxt = IDLE;
    end
  end

  assign imem_addr = pc;

  fetch_queue u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect),
    .count    (q_count),
    .head_vld (head_vld),
    .head_dat (head_dat)
  );

  assign ir       = head_dat.instr;
  assign ir_pc    = ADDR_W'(head_dat.pc);
  assign ir_valid = head_vld;

endmodule

// File: tb/tb_instr_fetch.sv
// Purpose: randomized + directed check of instr_fetch against a queue-level reference model.
// Latency: model expects a response-carried instruction at the head one cycle after rvalid.
// Backpressure: ir_ready, imem_gnt and imem_rvalid are randomized.
module tb_instr_fetch;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  fetch_entry_t q[$];
  fetch_entry_t pop_log[$];
  logic [15:0]  gnt_log[$];
  logic [15:0]  mpc;
  logic [15:0]  exp_stream;
  logic         pend_vld;
  logic         pend_disc;
  logic [15:0]  pend_addr;
  int           pend_age;
  int           gnt_pct;
  int           rv_pct;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    if (a == 16'h0000) return 16'hC0A1;
    if (a == 16'h0001) return 16'h8001;
    t = a * 16'h9E37;
    return t ^ 16'h3C5A;
  endfunction

  task automatic do_reset();
    rst_n       = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    halt        = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",   32'(imem_req),  32'(0));
    chk("rst_addr",  32'(imem_addr), 32'(16'h0000));
    chk("rst_ir",    32'(ir),        32'(0));
    chk("rst_ir_pc", 32'(ir_pc),     32'(0));
    chk("rst_valid", 32'(ir_valid),  32'(0));
    chk("rst_halt",  32'(halted),    32'(0));
    q.delete();
    pop_log.delete();
    gnt_log.delete();
    mpc        = 16'h0000;
    exp_stream = 16'h0000;
    pend_vld   = 1'b0;
    pend_disc  = 1'b0;
    pend_addr  = 16'h0;
    pend_age   = 0;
    rst_n      = 1'b1;
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle(input logic rdy, input logic rd, input logic [15:0] rd_pc, input logic hlt);
    logic         fire_g;
    logic         fire_r;
    logic         do_pop;
    fetch_entry_t e;
    chk("ir_valid", 32'(ir_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("ir",    32'(ir),    32'(q[0].instr));
      chk("ir_pc", 32'(ir_pc), 32'(q[0].pc));
    end
    if (imem_req) begin
      chk("req_addr", 32'(imem_addr), 32'(mpc));
      chk("req_room", 32'(q.size() < 2 && !pend_vld), 32'(1));
    end
    if (halted) chk("halt_quiet", 32'(imem_req || pend_vld), 32'(0));

    ir_ready    = rdy;
    redirect    = rd;
    redirect_pc = rd_pc;
    halt        = hlt;
    imem_gnt    = imem_req && !pend_vld && ($urandom_range(0, 99) < gnt_pct);
    imem_rvalid = pend_vld && (pend_age >= 1) && ($urandom_range(0, 99) < rv_pct);
    imem_rdata  = imem_rvalid ? mem_word(pend_addr) : 16'($urandom);
    fire_g      = imem_req && imem_gnt;
    fire_r      = imem_rvalid;
    do_pop      = rdy && (q.size() != 0);

    if (rd) begin
      q.delete();
    end else begin
      if (do_pop) begin
        chk("stream_pc", 32'(q[0].pc), 32'(exp_stream));
        exp_stream = q[0].pc + 16'd1;
        pop_log.push_back(q[0]);
        void'(q.pop_front());
      end
      if (fire_r && !pend_disc) begin
        chk("q_room", 32'(q.size() < 2), 32'(1));
        e.instr = mem_word(pend_addr);
        e.pc    = pend_addr;
        q.push_back(e);
      end
    end
    if (fire_r) pend_vld = 1'b0;
    if (rd) exp_stream = rd_pc;
    if (fire_g) begin
      gnt_log.push_back(imem_addr);
      pend_vld  = 1'b1;
      pend_addr = imem_addr;
      pend_disc = rd;
      pend_age  = 0;
    end else if (rd && pend_vld) begin
      pend_disc = 1'b1;
    end
    if (rd)          mpc = rd_pc;
    else if (fire_g) mpc = mpc + 16'd1;
    if (pend_vld) pend_age++;
    @(negedge clk);
  endtask

  initial begin
    int   np;
    logic hl;
    rst_n   = 1'b0;
    gnt_pct = 100;
    rv_pct  = 100;

    // in-order fetch from reset with 1-cycle memory
    do_reset();
    repeat (12) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t1_ngnt", 32'(gnt_log.size() >= 2 && pop_log.size() >= 2), 32'(1));
    chk("t1_gnt0", 32'(gnt_log[0]), 32'(16'h0000));
    chk("t1_gnt1", 32'(gnt_log[1]), 32'(16'h0001));
    chk("t1_ir0",  32'(pop_log[0].instr), 32'(16'hC0A1));
    chk("t1_pc0",  32'(pop_log[0].pc),    32'(16'h0000));
    chk("t1_ir1",  32'(pop_log[1].instr), 32'(16'h8001));
    chk("t1_pc1",  32'(pop_log[1].pc),    32'(16'h0001));

    // decoder stalled: two fetches fill the queue, no third until a pop
    do_reset();
    repeat (20) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_ngnt",  32'(gnt_log.size()), 32'(2));
    chk("t2_valid", 32'(ir_valid), 32'(1));
    chk("t2_ir",    32'(ir), 32'(16'hC0A1));
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_ngnt3", 32'(gnt_log.size()), 32'(3));
    chk("t2_gnt2",  32'(gnt_log[2]), 32'(16'h0002));

    // redirect while addr 2 is outstanding
    do_reset();
    for (int i = 0; i < 60 && gnt_log.size() < 3; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_reach", 32'(gnt_log.size()), 32'(3));
    rv_pct = 0;
    cycle(1'b1, 1'b1, 16'h0040, 1'b0);
    chk("t3_flush", 32'(ir_valid), 32'(0));
    np     = pop_log.size();
    rv_pct = 100;
    repeat (15) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_more", 32'(pop_log.size() > np && gnt_log.size() > 3), 32'(1));
    chk("t3_gnt",  32'(gnt_log[3]), 32'(16'h0040));
    chk("t3_pc",   32'(pop_log[np].pc), 32'(16'h0040));

    // redirect and pop together with a full queue
    do_reset();
    for (int i = 0; i < 30 && q.size() < 2; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t4_full", 32'(ir_valid), 32'(1));
    cycle(1'b1, 1'b1, 16'h0080, 1'b0);
    chk("t4_flush", 32'(ir_valid), 32'(0));
    np = pop_log.size();
    repeat (15) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t4_more", 32'(pop_log.size() > np), 32'(1));
    chk("t4_pc",   32'(pop_log[np].pc), 32'(16'h0080));

    // PC wrap
    do_reset();
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0);
    repeat (12) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_ngnt", 32'(gnt_log.size() >= 2), 32'(1));
    chk("t5_gnt0", 32'(gnt_log[0]), 32'(16'hFFFF));
    chk("t5_gnt1", 32'(gnt_log[1]), 32'(16'h0000));

    // halt during WAIT, redirect while halted, release
    do_reset();
    rv_pct = 0;
    for (int i = 0; i < 20 && gnt_log.size() < 1; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    rv_pct = 100;
    repeat (5) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    chk("t6_halted", 32'(halted),   32'(1));
    chk("t6_noreq",  32'(imem_req), 32'(0));
    chk("t6_drain",  32'(pop_log.size()), 32'(1));
    cycle(1'b1, 1'b1, 16'h0010, 1'b1);
    repeat (3) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    chk("t6_still",  32'(halted), 32'(1));
    chk("t6_nofetch", 32'(gnt_log.size()), 32'(1));
    for (int i = 0; i < 20 && gnt_log.size() < 2; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_resume", 32'(gnt_log.size()), 32'(2));
    chk("t6_addr",   32'(gnt_log[1]), 32'(16'h0010));

    // random traffic, with a reset in the middle
    gnt_pct = 60;
    rv_pct  = 50;
    hl      = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 99) < 3) hl = ~hl;
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 16'($urandom), hl);
    end
    chk("rand_progress", 32'(pop_log.size() > 20), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage of the 16-bit processor; sits directly upstream of the instruction decoder.
- Owns the PC and issues word reads to instruction memory over a request/grant/response interface.
- Buffers returned instructions in a 2-entry prefetch queue and presents them, with their PC, to the decoder over a valid/ready handshake.
- Supports branch redirect from execute, which flushes the stage, and an external halt.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width (word addressed).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request valid.
- imem_addr  out  ADDR_W  read address; held stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after gnt, in order.
- imem_rdata  in  16  instruction word.
- ir  out  16  instruction at queue head, to decoder.
- ir_pc  out  ADDR_W  address of ir.
- ir_valid  out  1  queue head valid.
- ir_ready  in  1  decoder consumes head when ir_valid && ir_ready.
- redirect  in  1  branch taken; flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address.
- halt  in  1  level; stop issuing fetches.
- halted  out  1  no fetch outstanding and halt asserted.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; queue empty; no request outstanding; discard flag clear; state IDLE.
  - All outputs 0, except imem_addr=RESET_PC.
- States: IDLE, REQ, WAIT, HALTED.
  - IDLE: if halt, go to HALTED. Else if free slots (2 − occupancy − outstanding) > 0, go to REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt: pc<=pc+1 (wraps modulo 2^ADDR_W), outstanding=1, go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid: push {rdata, address} unless discard is set. Clear outstanding and discard. Go to IDLE.
  - HALTED: halted=1, imem_req=0. Leave to IDLE when halt deasserts.
- Throughput: at most one request outstanding. Minimum fetch issue is once every 3 cycles with 1-cycle memory latency.
- Queue:
  - Push at tail on accepted response. Pop on ir_valid && ir_ready.
  - Simultaneous push and pop is allowed when full, with no data loss, because a slot is reserved by the outstanding count.
  - ir and ir_pc are registered and change only on pop, push-to-empty, or flush. They are stable while ir_valid && !ir_ready.
  - First instruction reaches ir_valid 1 cycle after its imem_rvalid.
- Redirect (any state, highest priority):
  - Next cycle: pc=redirect_pc, queue cleared, ir_valid=0, state IDLE.
  - If a request is outstanding, set discard so its response is dropped, and stay in WAIT until it returns.
  - A pop in the same cycle as redirect is ignored.
  - Redirect in REQ: imem_req drops next cycle. If gnt also occurred that same cycle, the request becomes outstanding with discard set.
- Halt:
  - Sampled only in IDLE; an in-flight request completes normally.
  - The queue still drains to the decoder while halted.
  - Redirect while HALTED updates pc and flushes, and remains HALTED.
- Reset mid-operation: immediate return to reset state. Any later imem_rvalid for a pre-reset request is the memory's responsibility; the memory is reset by the same rst_n.

Decomposition:
- Shared package (proc_pkg):
  - INSTR_W=16, ADDR_W default.
  - Fetch state enum {IDLE, REQ, WAIT, HALTED}.
  - Fetch queue entry struct {instr[15:0], pc}.
- One sub-module, fetch_queue: 2-entry FIFO with push, pop, flush, count, and head outputs.
- PC, FSM and discard logic live in instr_fetch.

Test Plan:
- Reset release, memory returns 16'hC0A1 at addr 0 and 16'h8001 at addr 1 with 1-cycle latency, ir_ready=1 → requests to 0 then 1; ir=C0A1/ir_pc=0, then ir=8001/ir_pc=1.
- ir_ready=0 throughout → exactly 2 grants (addr 0, 1), ir_valid=1, ir=first word held stable; no third imem_req until one pop.
- Redirect to 16'h0040 while the response for addr 2 is outstanding → response dropped; next request addr 0x40; queue empty after redirect; first ir_pc=0x40.
- Redirect and pop in the same cycle with the queue full → queue empty next cycle; no instruction from the old path is ever presented.
- PC=16'hFFFF fetch → next imem_addr=16'h0000.
- Halt asserted in WAIT → response pushed, then halted=1, imem_req=0. Redirect to 0x10 while halted, then deassert halt → next fetch addr 0x10.
